// File: rtl/llki_pkg.sv
// Shared constants and types for the LLKI protocol processor.
package llki_pkg;

    // TileLink-UL channel A opcodes
    localparam logic [2:0] A_PUTFULLDATA    = 3'd0;
    localparam logic [2:0] A_PUTPARTIALDATA = 3'd1;
    localparam logic [2:0] A_GET            = 3'd4;

    // TileLink-UL channel D opcodes
    localparam logic [2:0] D_ACCESSACK      = 3'd0;
    localparam logic [2:0] D_ACCESSACKDATA  = 3'd1;

    // LLKI commands carried in word 1 [63:56]
    localparam logic [7:0] LOAD_KEY_REQ     = 8'h00;
    localparam logic [7:0] CLEAR_KEY_REQ    = 8'h01;

    // Seven-word packet leaves room for at most five key words
    localparam logic [7:0] MAX_KEYS         = 8'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DELAY     = 2'd1,
        ST_LOAD_BUSY = 2'd2,
        ST_WAIT4ACK  = 2'd3
    } state_t;

    // Checksum fold: the two halves of the accumulator added in 16 bits
    // (the carry out is dropped, not wrapped back in).
    function automatic logic [15:0] fold16(input logic [31:0] s);
        return s[15:0] + s[31:16];
    endfunction

endpackage

// File: rtl/llki_tl_slave.sv
// TL-UL single-outstanding handshake and registered response channel.
module llki_tl_slave
    import llki_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [1:0]  a_size,
    input  logic [7:0]  a_source,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_size,
    output logic [7:0]  d_source,
    output logic [63:0] d_data,
    input  logic [63:0] status,
    output logic        accept
);

    logic busy;

    assign a_ready = ~busy;
    assign d_valid = busy;
    assign accept  = a_valid & ~busy;

    // Hold one request until its ack is taken; status is resampled every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            d_opcode <= 3'd0;
            d_size   <= 2'd0;
            d_source <= 8'd0;
            d_data   <= 64'd0;
        end else begin
            d_data <= status;
            if (accept) begin
                busy     <= 1'b1;
                d_size   <= a_size;
                d_source <= a_source;
                d_opcode <= (a_opcode == A_GET) ? D_ACCESSACKDATA : D_ACCESSACK;
            end else if (busy && d_ready) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/llki_pp.sv
// LLKI protocol processor: packet collection, validation and key-interface sequencing.
module llki_pp
    import llki_pkg::*;
#(
    parameter logic [15:0] MY_ID = 16'h0000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [1:0]  a_size,
    input  logic [7:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [2:0]  d_param,
    output logic [1:0]  d_size,
    output logic [7:0]  d_source,
    output logic        d_sink,
    output logic        d_denied,
    output logic        d_corrupt,
    output logic [63:0] d_data,
    output logic [63:0] key_data,
    output logic        key_valid,
    input  logic        key_ready,
    input  logic        key_complete,
    output logic        clear_key,
    input  logic        clear_key_ack
);

    state_t      state, state_nxt;
    logic [63:0] pkt [8];
    logic [31:0] sum;
    logic [2:0]  wr_p, key_id;
    logic        done, err, accept;
    logic [63:0] status;
    logic [15:0] dst;
    logic [7:0]  cmd, cnt;
    logic        complete, load_ok, pkt_ok, last_key, store;
    logic        start_load, start_clr, reject, next_key, finish;
    logic        unused_inputs;

    assign d_param   = 3'd0;
    assign d_sink    = 1'b0;
    assign d_denied  = 1'b0;
    assign d_corrupt = 1'b0;
    assign unused_inputs = ^{a_param, a_address, a_mask};

    assign status = {57'd0, wr_p, key_complete, key_ready, err, done};

    llki_tl_slave u_tl (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_size   (a_size),
        .a_source (a_source),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_opcode (d_opcode),
        .d_size   (d_size),
        .d_source (d_source),
        .d_data   (d_data),
        .status   (status),
        .accept   (accept)
    );

    assign dst = pkt[0][47:32];
    assign cmd = pkt[1][63:56];
    assign cnt = pkt[1][55:48];

    // Length is in bytes; its word count is compared with the write pointer.
    assign complete = (pkt[0][31:19] == {10'd0, wr_p}) && (wr_p != 3'd0);
    assign load_ok  = (cmd == LOAD_KEY_REQ) && (cnt != 8'd0) && (cnt <= MAX_KEYS);
    assign pkt_ok   = (fold16(sum) == 16'hFFFF) && (dst == MY_ID) &&
                      (load_ok || (cmd == CLEAR_KEY_REQ));
    assign last_key = ({5'd0, key_id} == (cnt - 8'd1));
    assign store    = accept && (a_opcode == A_PUTFULLDATA) &&
                      (state == ST_IDLE) && !complete;
    assign key_data = pkt[key_id + 3'd2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (complete && pkt_ok)
                              state_nxt = (cmd == LOAD_KEY_REQ) ? ST_DELAY : ST_WAIT4ACK;
            ST_DELAY:     state_nxt = ST_LOAD_BUSY;
            ST_LOAD_BUSY: if (key_ready) state_nxt = last_key ? ST_IDLE : ST_DELAY;
            ST_WAIT4ACK:  if (clear_key_ack) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Per-state action strobes consumed by the datapath
    always_comb begin
        start_load = 1'b0;
        start_clr  = 1'b0;
        reject     = 1'b0;
        next_key   = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: if (complete) begin
                if (!pkt_ok)                  reject     = 1'b1;
                else if (cmd == LOAD_KEY_REQ) start_load = 1'b1;
                else                          start_clr  = 1'b1;
            end
            ST_LOAD_BUSY: if (key_ready) begin
                if (last_key) finish   = 1'b1;
                else          next_key = 1'b1;
            end
            ST_WAIT4ACK: if (clear_key_ack) finish = 1'b1;
            default: ;
        endcase
    end

    // Packet buffer, checksum accumulator, pointers, status flags and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) pkt[i] <= 64'd0;
            sum       <= 32'd0;
            wr_p      <= 3'd0;
            key_id    <= 3'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            key_valid <= 1'b0;
            clear_key <= 1'b0;
        end else begin
            key_valid <= start_load | next_key;
            clear_key <= start_clr;
            if (store) begin
                pkt[wr_p] <= a_data;
                sum  <= sum + 32'(a_data[15:0]) + 32'(a_data[31:16]) +
                              32'(a_data[47:32]) + 32'(a_data[63:48]);
                wr_p <= wr_p + 3'd1;
                done <= 1'b0;
            end
            if (reject) begin
                err  <= 1'b1;
                done <= 1'b1;
                wr_p <= 3'd0;
                sum  <= 32'd0;
            end
            if (finish) begin
                done <= 1'b1;
                wr_p <= 3'd0;
                sum  <= 32'd0;
            end
            if (start_load) begin
                key_id <= 3'd0;
                err    <= 1'b0;
            end
            if (start_clr) err    <= 1'b0;
            if (next_key)  key_id <= key_id + 3'd1;
        end
    end

endmodule

// File: tb/tb_llki_pp.sv
// Self-checking bench for llki_pp: table of packet scenarios, hand sequences, random packets.
module tb_llki_pp;
    import llki_pkg::*;

    localparam logic [15:0] MY_ID = 16'h1234;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic        d_corrupt;
    logic [63:0] d_data;
    logic [63:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic        key_complete;
    logic        clear_key;
    logic        clear_key_ack;

    llki_pp #(.MY_ID(MY_ID)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_corrupt(d_corrupt), .d_data(d_data),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .key_complete(key_complete), .clear_key(clear_key), .clear_key_ack(clear_key_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core-side responder and key/clear monitor ----------------
    logic [63:0] keys_q[$];
    int  clr_cnt  = 0;
    bit  auto_kr  = 1'b1;
    int  kr_cnt   = 0;
    int  ack_wait = 0;
    int  since_kv = 100;

    initial begin
        key_ready     = 1'b0;
        clear_key_ack = 1'b0;
        forever begin
            @(negedge clk);
            since_kv++;
            if (key_valid === 1'b1) begin
                keys_q.push_back(key_data);
                check("kv_gap", 64'(since_kv >= 2), 64'd1);
                since_kv = 0;
                if (auto_kr) kr_cnt = 2;
            end
            key_ready = (kr_cnt > 0);
            if (kr_cnt > 0) kr_cnt--;
            clear_key_ack = 1'b0;
            if (ack_wait > 0) begin
                ack_wait--;
                if (ack_wait == 0) clear_key_ack = 1'b1;
            end
            if (clear_key === 1'b1) begin
                clr_cnt++;
                ack_wait = 3;
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic tl_req(input logic [2:0] op, input logic [63:0] data, input logic [7:0] src,
                          input logic [1:0] sz, output logic [63:0] rdata, output logic [2:0] dop);
        int n;
        a_opcode = op; a_data = data; a_source = src; a_size = sz; a_valid = 1'b1;
        n = 0;
        while (a_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (a_ready !== 1'b1) check("a_ready_timeout", 64'(a_ready), 64'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        n = 0;
        while (d_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (d_valid !== 1'b1) check("d_valid_timeout", 64'(d_valid), 64'd1);
        rdata = d_data;
        dop   = d_opcode;
        @(posedge clk); #1;
    endtask

    task automatic poll(output logic [63:0] st);
        logic [2:0] dop;
        tl_req(A_GET, 64'd0, 8'hA5, 2'd3, st, dop);
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mem [8];

    function automatic logic [15:0] fold_of(input logic [63:0] w [8], input int nw);
        logic [31:0] s = 0;
        for (int i = 0; i < nw; i++)
            for (int h = 0; h < 4; h++) s += 32'(w[i][h*16 +: 16]);
        return s[15:0] + s[31:16];
    endfunction

    function automatic bit model_ok(input logic [63:0] w [8], input int nw);
        logic [7:0] c  = w[1][63:56];
        logic [7:0] kc = w[1][55:48];
        bit cmd_ok = (c == 8'h01) || (c == 8'h00 && kc >= 1 && kc <= 5);
        return (fold_of(w, nw) == 16'hFFFF) && (w[0][47:32] == MY_ID) && cmd_ok;
    endfunction

    task automatic build(input logic [15:0] dst, input logic [7:0] cmd, input logic [7:0] cnt,
                         input int nw, input logic [2:0] lowlen, input bit corrupt,
                         output logic [63:0] w [8]);
        logic [15:0] c;
        logic [15:0] len = 16'(nw * 8) | 16'(lowlen);
        for (int i = 0; i < 8; i++) w[i] = {$urandom, $urandom};
        w[1] = {cmd, cnt, w[1][47:0]};
        w[0] = {w[0][63:48], dst, len, 16'h0000};
        c = 16'hFFFF - fold_of(w, nw);
        w[0][15:0] = c;
        if (fold_of(w, nw) != 16'hFFFF) begin
            w[0][15:0] = c - 16'd1;
            if (fold_of(w, nw) != 16'hFFFF)
                for (int k = 0; k < 65536; k++) begin
                    w[0][15:0] = 16'(k);
                    if (fold_of(w, nw) == 16'hFFFF) break;
                end
        end
        if (corrupt) w[0][15:0] = w[0][15:0] + 16'd1;
    endtask

    task automatic run_pkt(input logic [63:0] w [8], input int nw, output logic [63:0] st);
        logic [63:0] rd;
        logic [2:0]  dop;
        int n;
        keys_q.delete();
        clr_cnt = 0;
        for (int i = 0; i < nw; i++) begin
            tl_req(A_PUTFULLDATA, w[i], 8'(i), 2'd3, rd, dop);
            mem[i] = w[i];
        end
        n = 0;
        do begin poll(rd); n++; end while (rd[0] !== 1'b1 && n < 80);
        if (rd[0] !== 1'b1) check("done_timeout", rd, 64'd1);
        poll(st);
    endtask

    task automatic check_keys(input string tag, input int nexp);
        check({tag, "_nkeys"}, 64'(keys_q.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < keys_q.size(); i++)
            check({tag, "_key"}, keys_q[i], mem[2 + i]);
    endtask

    typedef struct {
        logic [15:0] dst;
        logic [7:0]  cmd;
        logic [7:0]  cnt;
        int          nw;
        bit          corrupt;
        logic [63:0] exp_st;
        int          exp_keys;
        int          exp_clr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [63:0] w [8];
        logic [63:0] st, rd;
        logic [2:0]  dop;
        bit ok;
        int nk, n;

        tbl[0] = '{MY_ID,       8'h00, 8'd2, 4, 1'b0, 64'h1, 2, 0};  // load two keys
        tbl[1] = '{MY_ID,       8'h01, 8'd0, 2, 1'b0, 64'h1, 0, 1};  // clear key
        tbl[2] = '{MY_ID,       8'h00, 8'd2, 4, 1'b1, 64'h3, 0, 0};  // checksum off by one
        tbl[3] = '{MY_ID + 16'd1, 8'h00, 8'd1, 3, 1'b0, 64'h3, 0, 0};  // wrong destination
        tbl[4] = '{MY_ID,       8'h00, 8'd1, 3, 1'b0, 64'h1, 1, 0};  // recovers after error
        tbl[5] = '{MY_ID,       8'h00, 8'd0, 2, 1'b0, 64'h3, 0, 0};  // zero key count
        tbl[6] = '{MY_ID,       8'h00, 8'd6, 7, 1'b0, 64'h3, 0, 0};  // key count above five
        tbl[7] = '{MY_ID,       8'h07, 8'd1, 3, 1'b0, 64'h3, 0, 0};  // unknown command
        tbl[8] = '{MY_ID,       8'h00, 8'd5, 7, 1'b0, 64'h1, 5, 0};  // largest packet
        tbl[9] = '{MY_ID,       8'h01, 8'd0, 7, 1'b0, 64'h1, 0, 1};  // clear in long packet

        for (int i = 0; i < 8; i++) mem[i] = 64'd0;
        rst = 1'b1; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0;
        a_source = 8'd0; a_address = 32'd0; a_mask = 8'hFF; a_data = 64'd0;
        d_ready = 1'b1; key_complete = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready",   64'(a_ready),   64'd1);
        check("rst_d_valid",   64'(d_valid),   64'd0);
        check("rst_key_valid", 64'(key_valid), 64'd0);
        check("rst_clear_key", 64'(clear_key), 64'd0);
        check("rst_d_data",    d_data,         64'd0);
        check("rst_d_opcode",  64'(d_opcode),  64'd0);
        check("rst_d_size",    64'(d_size),    64'd0);
        check("rst_d_source",  64'(d_source),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Partial packet: pointer visible in status, PutPartialData not stored
        keys_q.delete(); clr_cnt = 0;
        build(MY_ID, 8'h01, 8'd0, 2, 3'd5, 1'b0, w);
        tl_req(A_PUTFULLDATA, w[0], 8'd1, 2'd3, rd, dop);
        mem[0] = w[0];
        check("put_ack_opcode", 64'(dop), 64'(D_ACCESSACK));
        poll(st);
        check("wrp_one", st, 64'h10);
        tl_req(A_PUTPARTIALDATA, 64'hDEAD_BEEF_0000_0000, 8'd2, 2'd3, rd, dop);
        check("partial_ack_opcode", 64'(dop), 64'(D_ACCESSACK));
        poll(st);
        check("partial_not_stored", st, 64'h10);
        tl_req(A_PUTFULLDATA, w[1], 8'd3, 2'd3, rd, dop);
        mem[1] = w[1];
        n = 0;
        do begin poll(st); n++; end while (st[0] !== 1'b1 && n < 80);
        poll(st);
        check("partial_seq_status", st, 64'h1);
        check("partial_seq_clr", 64'(clr_cnt), 64'd1);

        // Get response fields with back-pressure on D
        d_ready = 1'b0;
        a_opcode = A_GET; a_source = 8'd5; a_size = 2'd3; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("get_d_valid",   64'(d_valid),   64'd1);
        check("get_d_opcode",  64'(d_opcode),  64'd1);
        check("get_d_source",  64'(d_source),  64'd5);
        check("get_d_size",    64'(d_size),    64'd3);
        check("get_d_param",   64'(d_param),   64'd0);
        check("get_d_sink",    64'(d_sink),    64'd0);
        check("get_d_denied",  64'(d_denied),  64'd0);
        check("get_d_corrupt", 64'(d_corrupt), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("get_hold_a_ready", 64'(a_ready), 64'd0);
            check("get_hold_d_valid", 64'(d_valid), 64'd1);
        end
        d_ready = 1'b1;
        @(posedge clk); #1;
        check("get_release_d_valid", 64'(d_valid), 64'd0);
        check("get_release_a_ready", 64'(a_ready), 64'd1);

        // Table of packet scenarios
        foreach (tbl[i]) begin
            build(tbl[i].dst, tbl[i].cmd, tbl[i].cnt, tbl[i].nw, 3'(i), tbl[i].corrupt, w);
            run_pkt(w, tbl[i].nw, st);
            check($sformatf("tbl%0d_status", i), st, tbl[i].exp_st);
            check($sformatf("tbl%0d_clr", i), 64'(clr_cnt), 64'(tbl[i].exp_clr));
            check_keys($sformatf("tbl%0d", i), tbl[i].exp_keys);
        end

        // Random packets against the model
        for (int r = 0; r < 24; r++) begin
            logic [15:0] dst;
            logic [7:0]  cmd;
            int nw;
            dst = ($urandom_range(0, 3) == 0) ? (MY_ID ^ 16'h0001) : MY_ID;
            case ($urandom_range(0, 4))
                2:       cmd = 8'h01;
                3:       cmd = 8'($urandom);
                default: cmd = 8'h00;
            endcase
            nw = $urandom_range(2, 7);
            build(dst, cmd, 8'($urandom_range(0, 6)), nw, 3'($urandom), $urandom_range(0, 4) == 0, w);
            ok = model_ok(w, nw);
            run_pkt(w, nw, st);
            check($sformatf("rnd%0d_status", r), st, ok ? 64'h1 : 64'h3);
            nk = (ok && w[1][63:56] == 8'h00) ? int'(w[1][55:48]) : 0;
            check($sformatf("rnd%0d_clr", r), 64'(clr_cnt),
                  64'((ok && w[1][63:56] == 8'h01) ? 1 : 0));
            check_keys($sformatf("rnd%0d", r), nk);
        end

        // Reset while waiting for key_ready
        auto_kr = 1'b0;
        keys_q.delete();
        build(MY_ID, 8'h00, 8'd3, 5, 3'd0, 1'b0, w);
        for (int i = 0; i < 5; i++) tl_req(A_PUTFULLDATA, w[i], 8'(i), 2'd3, rd, dop);
        repeat (6) @(posedge clk);
        #1;
        check("midload_one_key", 64'(keys_q.size()), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midload_key_valid", 64'(key_valid), 64'd0);
        check("midload_a_ready",   64'(a_ready),   64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("midload_no_more_keys", 64'(keys_q.size()), 64'd1);
        poll(st);
        check("midload_status", st, 64'd0);
        auto_kr = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a loop above never returns
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
